// File: rtl/exwb_arbiter_pkg.sv
// Shared types and constants for the execute-to-writeback arbiter.
// Unit indices match the existing EX_*_UNIT encoding and double as cdb_kind.
package exwb_arbiter_pkg;

  localparam int INST_TAG_WIDTH = 6;
  localparam int COMMON_WIDTH   = 32;

  // A tag of zero on a source port or on the CDB means "nothing here".
  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '0;

  localparam int         EX_UNIT_NUM    = 5;
  localparam logic [2:0] EX_ALU_UNIT    = 3'd0;
  localparam logic [2:0] EX_FWD_UNIT    = 3'd1;
  localparam logic [2:0] EX_JUMP_UNIT   = 3'd2;
  localparam logic [2:0] EX_BRANCH_UNIT = 3'd3;
  localparam logic [2:0] EX_MEM_UNIT    = 3'd4;

  // A jump writes back its link address, one instruction past ori_pc.
  localparam logic [COMMON_WIDTH-1:0] JUMP_LINK_OFFSET = 32'd4;

  // One writeback result, as buffered per source and as driven onto the CDB.
  typedef struct packed {
    logic [INST_TAG_WIDTH-1:0] tag;
    logic [COMMON_WIDTH-1:0]   value;
    logic [COMMON_WIDTH-1:0]   next_pc;
    logic                      cmp_res;
    logic [2:0]                kind;
  } cdb_pkt_t;

  // Round-robin successor of a unit index, wrapping from the last unit to 0.
  function automatic logic [2:0] rr_next(input logic [2:0] idx);
    return (idx == 3'(EX_UNIT_NUM - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/exwb_arbiter_wb_fifo.sv
// Per-source result FIFO. Ready and empty come straight from the registered
// count, so there is no combinational path from pop to ready.
module wb_fifo
  import exwb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  cdb_pkt_t push_pkt,
  input  logic     pop,
  output cdb_pkt_t head,
  output logic     ready,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  cdb_pkt_t      mem [DEPTH];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_pkt;
  end

  assign head  = mem[rd_ptr];
  assign ready = (count != CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/exwb_arbiter.sv
// Writeback arbiter: buffers results from the execute units, picks one per
// cycle round-robin and broadcasts it on a registered common data bus.
module exwb_arbiter
  import exwb_arbiter_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = EX_UNIT_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [INST_TAG_WIDTH-1:0] src_target  [NUM_SRC],
  input  logic [COMMON_WIDTH-1:0]   src_result  [NUM_SRC],
  input  logic [COMMON_WIDTH-1:0]   src_next_pc [NUM_SRC],
  input  logic                      src_cmp_res [NUM_SRC],
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [INST_TAG_WIDTH-1:0] cdb_tag,
  output logic [COMMON_WIDTH-1:0]   cdb_value,
  output logic [COMMON_WIDTH-1:0]   cdb_next_pc,
  output logic                      cdb_cmp_res,
  output logic [2:0]                cdb_kind
);

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] empty;
  cdb_pkt_t           push_pkt [NUM_SRC];
  cdb_pkt_t           head     [NUM_SRC];

  logic [2:0] rr;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [3:0] scan;
  cdb_pkt_t   out_pkt;

  // Build the packet each source would enqueue; jumps store the link address.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i]             = (src_target[i] != TAG_INVALID) && src_ready[i];
      push_pkt[i].tag     = src_target[i];
      push_pkt[i].value   = (i == int'(EX_JUMP_UNIT)) ? src_result[i] + JUMP_LINK_OFFSET
                                                      : src_result[i];
      push_pkt[i].next_pc = src_next_pc[i];
      push_pkt[i].cmp_res = src_cmp_res[i];
      push_pkt[i].kind    = 3'(i);
    end
  end

  // One FIFO per execute unit.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign pop[g] = grant_valid && (grant_idx == 3'(g)) && !flush;

    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (push[g]),
      .push_pkt (push_pkt[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .ready    (src_ready[g]),
      .empty    (empty[g])
    );
  end

  // Round-robin scan: first non-empty FIFO starting at rr, wrapping past the last unit.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr;
    scan        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, rr} + 4'(k);
      if (scan >= 4'(NUM_SRC)) scan = scan - 4'(NUM_SRC);
      if (!grant_valid && !empty[scan[2:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan[2:0];
      end
    end
  end

  // CDB output register and round-robin pointer; idle cycles invalidate the tag only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      out_pkt   <= '{tag: TAG_INVALID, default: '0};
      rr        <= '0;
    end else if (flush) begin
      cdb_valid   <= 1'b0;
      out_pkt.tag <= TAG_INVALID;
    end else if (grant_valid) begin
      cdb_valid <= 1'b1;
      out_pkt   <= head[grant_idx];
      rr        <= rr_next(grant_idx);
    end else begin
      cdb_valid   <= 1'b0;
      out_pkt.tag <= TAG_INVALID;
    end
  end

  assign cdb_tag     = out_pkt.tag;
  assign cdb_value   = out_pkt.value;
  assign cdb_next_pc = out_pkt.next_pc;
  assign cdb_cmp_res = out_pkt.cmp_res;
  assign cdb_kind    = out_pkt.kind;

endmodule

// File: tb/tb_exwb_arbiter.sv
// Bench for exwb_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the writeback rules.
module tb_exwb_arbiter;
  import exwb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int NS    = 5;
  localparam int ALU = 0, FWD = 1, JMP = 2, BR = 3, MEM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [5:0]  tgt [NS];
  logic [31:0] res [NS];
  logic [31:0] npc [NS];
  logic        cmp [NS];
  logic [NS-1:0] ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [31:0] cdb_next_pc;
  logic        cdb_cmp_res;
  logic [2:0]  cdb_kind;

  int errors = 0;
  int checks = 0;

  exwb_arbiter #(.DEPTH(DEPTH), .NUM_SRC(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .src_target  (tgt),
    .src_result  (res),
    .src_next_pc (npc),
    .src_cmp_res (cmp),
    .src_ready   (ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .cdb_next_pc (cdb_next_pc),
    .cdb_cmp_res (cdb_cmp_res),
    .cdb_kind    (cdb_kind)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] value;
    logic [31:0] next_pc;
    logic        cmp;
    logic [2:0]  kind;
  } exp_t;

  exp_t          mq [NS][$];
  int            m_rr;
  logic          m_valid;
  exp_t          m_out;
  logic [NS-1:0] m_accept;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_rr     = 0;
    m_valid  = 1'b0;
    m_out    = '0;
    m_out.tag = TAG_INVALID;
    m_accept = '0;
  endtask

  // Applies one clock edge's worth of writeback rules to the model.
  task automatic model_update();
    exp_t e;
    int   g;
    for (int i = 0; i < NS; i++) m_accept[i] = (tgt[i] != TAG_INVALID) && (mq[i].size() != DEPTH);
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_valid   = 1'b0;
      m_out.tag = TAG_INVALID;
    end else begin
      g = -1;
      for (int k = 0; k < NS; k++)
        if (g < 0 && mq[(m_rr + k) % NS].size() > 0) g = (m_rr + k) % NS;
      if (g >= 0) begin
        m_out   = mq[g].pop_front();
        m_valid = 1'b1;
        m_rr    = (g + 1) % NS;
      end else begin
        m_valid   = 1'b0;
        m_out.tag = TAG_INVALID;
      end
      for (int i = 0; i < NS; i++) begin
        if (m_accept[i]) begin
          e.tag     = tgt[i];
          e.value   = (i == JMP) ? res[i] + 32'd4 : res[i];
          e.next_pc = npc[i];
          e.cmp     = cmp[i];
          e.kind    = 3'(i);
          mq[i].push_back(e);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    for (int i = 0; i < NS; i++) begin
      tgt[i] = '0;
      res[i] = '0;
      npc[i] = '0;
      cmp[i] = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_cmp_res, cdb_kind} !== {1'b0, TAG_INVALID, 32'h0, 32'h0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b tag=%0d val=%h npc=%h cmp=%0b kind=%0d, want all idle/zero",
               cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_cmp_res, cdb_kind);
    end
    checks++;
    if (ready !== 5'h1F) begin
      errors++;
      $display("FAIL reset_ready: got %b want 11111", ready);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got valid=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    tgt[ALU] = 6'd5;
    res[ALU] = 32'h1234;
    step();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got valid=%0b want 0 one edge after enqueue", cdb_valid);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_kind} !== {1'b1, 6'd5, 32'h1234, EX_ALU_UNIT}) begin
      errors++;
      $display("FAIL single_bcast: got v=%0b tag=%0d val=%h kind=%0d want v=1 tag=5 val=1234 kind=0",
               cdb_valid, cdb_tag, cdb_value, cdb_kind);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b0, TAG_INVALID, 32'h1234}) begin
      errors++;
      $display("FAIL single_idle: got v=%0b tag=%0d val=%h want v=0 tag=invalid val held 1234",
               cdb_valid, cdb_tag, cdb_value);
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < NS; i++) begin
      tgt[i] = 6'(i + 1);
      res[i] = 32'(100 + i);
    end
    step();
    clear_inputs();
    for (int i = 0; i < NS; i++) begin
      step();
      checks++;
      if ({cdb_valid, cdb_tag, cdb_kind} !== {1'b1, 6'(i + 1), 3'(i)}) begin
        errors++;
        $display("FAIL collide_order[%0d]: got v=%0b tag=%0d kind=%0d want v=1 tag=%0d kind=%0d",
                 i, cdb_valid, cdb_tag, cdb_kind, i + 1, i);
      end
    end
    // rr must have wrapped to 0: ALU beats MEM when both arrive together.
    tgt[ALU] = 6'd11;
    tgt[MEM] = 6'd12;
    step();
    clear_inputs();
    step();
    checks++;
    if ({cdb_valid, cdb_tag} !== {1'b1, 6'd11}) begin
      errors++;
      $display("FAIL collide_rr_wrap_first: got v=%0b tag=%0d want v=1 tag=11", cdb_valid, cdb_tag);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag} !== {1'b1, 6'd12}) begin
      errors++;
      $display("FAIL collide_rr_wrap_second: got v=%0b tag=%0d want v=1 tag=12", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_jump();
    do_reset();
    tgt[JMP] = 6'd9;
    res[JMP] = 32'h0000_1000;
    npc[JMP] = 32'h0000_2000;
    step();
    clear_inputs();
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_kind} !== {1'b1, 6'd9, 32'h1004, 32'h2000, EX_JUMP_UNIT}) begin
      errors++;
      $display("FAIL jump_link: got v=%0b tag=%0d val=%h npc=%h kind=%0d want v=1 tag=9 val=1004 npc=2000 kind=2",
               cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_kind);
    end
    tgt[JMP] = 6'd10;
    res[JMP] = 32'hFFFF_FFFC;
    npc[JMP] = 32'h0000_0040;
    step();
    clear_inputs();
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_next_pc} !== {1'b1, 6'd10, 32'h0, 32'h40}) begin
      errors++;
      $display("FAIL jump_wrap: got v=%0b tag=%0d val=%h npc=%h want v=1 tag=10 val=0 npc=40",
               cdb_valid, cdb_tag, cdb_value, cdb_next_pc);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0]    br_tags [3];
    logic [5:0]    seen [$];
    logic [NS-1:0] acc;
    int            br_i, bcast, accepted, nt;
    br_tags = '{6'd7, 6'd8, 6'd9};
    do_reset();
    bcast = 0; accepted = 0; nt = 0;
    for (int i = 0; i < 3; i++) begin
      tgt[i] = 6'(20 + nt);
      nt++;
    end
    tgt[BR] = br_tags[0];
    br_i = 1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NS; i++) acc[i] = (tgt[i] != 0) && ready[i];
      step();
      if (cdb_valid) begin
        bcast++;
        if (cdb_kind == EX_BRANCH_UNIT) seen.push_back(cdb_tag);
      end
      for (int i = 0; i < NS; i++) if (acc[i]) accepted++;
      if (c == 1) begin
        checks++;
        if (ready[BR] !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_low: got src_ready[branch]=%0b want 0 after second enqueue", ready[BR]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          tgt[i] = 6'(20 + (nt % 40));
          nt++;
        end
      end
      if (acc[BR]) begin
        if (br_i < 3) begin
          tgt[BR] = br_tags[br_i];
          br_i++;
        end else begin
          tgt[BR] = '0;
        end
      end
    end
    clear_inputs();
    for (int c = 0; c < 20; c++) begin
      step();
      if (cdb_valid) begin
        bcast++;
        if (cdb_kind == EX_BRANCH_UNIT) seen.push_back(cdb_tag);
      end
    end
    checks++;
    if (seen.size() != 3) begin
      errors++;
      $display("FAIL bp_branch_count: got %0d branch broadcasts want 3", seen.size());
    end else begin
      checks++;
      if ({seen[0], seen[1], seen[2]} !== {6'd7, 6'd8, 6'd9}) begin
        errors++;
        $display("FAIL bp_branch_order: got %0d,%0d,%0d want 7,8,9", seen[0], seen[1], seen[2]);
      end
    end
    checks++;
    if (bcast != accepted) begin
      errors++;
      $display("FAIL bp_conservation: got %0d broadcasts want %0d (accepted)", bcast, accepted);
    end
  endtask

  task automatic test_flush();
    do_reset();
    tgt[ALU] = 6'd1;
    tgt[FWD] = 6'd2;
    tgt[JMP] = 6'd3;
    step();
    clear_inputs();
    flush = 1'b1;
    tgt[ALU] = 6'd4;
    res[ALU] = 32'hDEAD;
    step();
    clear_inputs();
    checks++;
    if ({cdb_valid, cdb_tag} !== {1'b0, TAG_INVALID}) begin
      errors++;
      $display("FAIL flush_out: got v=%0b tag=%0d want v=0 tag=invalid", cdb_valid, cdb_tag);
    end
    checks++;
    if (ready !== 5'h1F) begin
      errors++;
      $display("FAIL flush_ready: got %b want 11111", ready);
    end
    tgt[BR] = 6'd6;
    res[BR] = 32'h66;
    cmp[BR] = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_stale: got v=%0b tag=%0d want v=0", cdb_valid, cdb_tag);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_cmp_res, cdb_kind} !== {1'b1, 6'd6, 32'h66, 1'b1, EX_BRANCH_UNIT}) begin
      errors++;
      $display("FAIL flush_after: got v=%0b tag=%0d val=%h cmp=%0b kind=%0d want v=1 tag=6 val=66 cmp=1 kind=3",
               cdb_valid, cdb_tag, cdb_value, cdb_cmp_res, cdb_kind);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_drained[%0d]: got v=%0b tag=%0d want v=0", c, cdb_valid, cdb_tag);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tgt[ALU] = 6'd5;
    res[ALU] = 32'hAAAA;
    tgt[FWD] = 6'd6;
    tgt[MEM] = 6'd7;
    step();
    clear_inputs();
    step();
    checks++;
    if ({cdb_valid, cdb_tag} !== {1'b1, 6'd5}) begin
      errors++;
      $display("FAIL arst_pre: got v=%0b tag=%0d want v=1 tag=5", cdb_valid, cdb_tag);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_cmp_res, cdb_kind} !== {1'b0, TAG_INVALID, 32'h0, 32'h0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL arst_immediate: got v=%0b tag=%0d val=%h kind=%0d want all idle/zero",
               cdb_valid, cdb_tag, cdb_value, cdb_kind);
    end
    checks++;
    if (ready !== 5'h1F) begin
      errors++;
      $display("FAIL arst_ready: got %b want 11111", ready);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL arst_no_stale[%0d]: got v=%0b tag=%0d want v=0", c, cdb_valid, cdb_tag);
      end
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] exp_ready;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (tgt[i] == 0 && $urandom_range(0, 1) == 1) begin
          tgt[i] = 6'($urandom_range(1, 63));
          res[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
          npc[i] = $urandom();
          cmp[i] = 1'($urandom_range(0, 1));
        end
      end
      flush = ($urandom_range(0, 49) == 0);
      step();
      checks++;
      if ({cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_cmp_res, cdb_kind} !== {m_valid, m_out}) begin
        errors++;
        $display("FAIL rand_cdb[%0d]: got %h want %h", c,
                 {cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_cmp_res, cdb_kind}, {m_valid, m_out});
      end
      for (int i = 0; i < NS; i++) exp_ready[i] = (mq[i].size() != DEPTH);
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, ready, exp_ready);
      end
      for (int i = 0; i < NS; i++) if (m_accept[i]) tgt[i] = '0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_collision();
    test_jump();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
